// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } md_state_e;

    localparam logic [MD_XLEN-1:0] DIV0_Q = '1;
    localparam logic [MD_XLEN-1:0] OVF_Q  = {1'b1, {(MD_XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_datapath.sv
// Operand registers, shared accumulator and sign fix-up for shift-add multiply
// and restoring divide; sequenced by load/prep/step/fix/fast strobes.
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            prep_i,
    input  logic            step_i,
    input  logic            fix_i,
    input  logic            fast_i,
    input  md_op_e          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] fast_val_i,
    output logic [XLEN-1:0] result_o
);

    md_op_e              op_q;
    logic [XLEN-1:0]     a_q, b_q, result_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN:0]       rem_q;
    logic                neg_res_q, neg_rem_q;

    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_abs, b_abs, rmd, fix_val;
    logic [XLEN:0]       add_sum, shl, trial;
    logic [2*XLEN-1:0]   prod;

    assign a_neg = (op_q inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a_q[XLEN-1];
    assign b_neg = (op_q inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) & b_q[XLEN-1];
    assign a_abs = a_neg ? -a_q : a_q;
    assign b_abs = b_neg ? -b_q : b_q;

    // Multiply keeps the multiplier in acc low half and shifts it out as the product grows.
    assign add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Divide shifts the dividend out of acc low half while the quotient shifts in behind it.
    assign shl     = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    assign trial   = shl - {1'b0, b_q};

    assign prod = neg_res_q ? -acc_q : acc_q;
    assign rmd  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        fix_val = rmd;
        case (op_q)
            MD_MUL, MD_DIV, MD_DIVU:       fix_val = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_val = prod[2*XLEN-1:XLEN];
            default:                       fix_val = rmd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= MD_MUL;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            if (load_i) begin
                op_q <= op_i;
                a_q  <= a_i;
                b_q  <= b_i;
            end
            if (prep_i) begin
                a_q       <= a_abs;
                b_q       <= b_abs;
                acc_q     <= {{XLEN{1'b0}}, a_abs};
                rem_q     <= '0;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
            end
            if (step_i) begin
                if (op_q[2]) begin
                    if (!trial[XLEN]) begin
                        rem_q             <= trial;
                        acc_q[XLEN-1:0]   <= {acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q             <= shl;
                        acc_q[XLEN-1:0]   <= {acc_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_q <= {add_sum, acc_q[XLEN-1:1]};
                end
            end
            if (fix_i) result_q <= fix_val;
            if (fast_i) result_q <= fast_val_i;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage RV32M controller: FSM, iteration counter, flush/stall handling and
// the divide-by-zero / signed-overflow fast path around muldiv_datapath.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       rd_q, rd_out_q;
    logic             done_q;

    md_op_e           op_e;
    logic             accept, div0, ovf, fast;
    logic [XLEN-1:0]  fast_val;

    assign op_e   = md_op_e'(op);
    assign accept = (state_q == S_IDLE) & start & ~flush;
    assign div0   = op[2] & (src_b == '0);
    assign ovf    = (op_e inside {MD_DIV, MD_REM}) & (src_a == OVF_Q) & (src_b == '1);
    assign fast   = div0 | ovf;

    // op[1] separates remainder ops from quotient ops.
    always_comb begin
        fast_val = '0;
        if (div0)     fast_val = op[1] ? src_a : DIV0_Q;
        else if (ovf) fast_val = op[1] ? '0    : OVF_Q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rd_q <= rd_in;
                        if (fast) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            rd_out_q <= rd_in;
                        end else begin
                            state_q <= S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    if (flush) state_q <= S_IDLE;
                    else begin
                        cnt_q   <= CNT_W'(XLEN - 1);
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush)              state_q <= S_IDLE;
                    else if (cnt_q == '0)   state_q <= S_FIX;
                    else                    cnt_q   <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    if (flush) state_q <= S_IDLE;
                    else begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        rd_out_q <= rd_q;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .prep_i     ((state_q == S_PREP) & ~flush),
        .step_i     ((state_q == S_RUN) & ~flush),
        .fix_i      ((state_q == S_FIX) & ~flush),
        .fast_i     (accept & fast),
        .op_i       (op_e),
        .a_i        (src_a),
        .b_i        (src_b),
        .fast_val_i (fast_val),
        .result_o   (result)
    );

    assign busy   = (state_q != S_IDLE);
    assign stall  = ((state_q == S_IDLE) & start) | (state_q inside {S_PREP, S_RUN, S_FIX});
    assign done   = done_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, flush and
// reset sequences, and random ops against a plain-arithmetic reference.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  last_rd  = '0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            default: begin
                if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
                if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return o[1] ? 32'h0 : 32'h8000_0000;
                case (o)
                    3'd4:    return 32'(ia / ib);
                    3'd5:    return a / b;
                    3'd6:    return 32'(ia % ib);
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 35;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; rd_in = rd;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                          input string name);
        int cyc;
        int stall_lo;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; rd_in = rd;
        #1 check({name, " stall@issue"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        stall_lo = 0;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (done) break;
            if (!stall) stall_lo++;
        end
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " stall-gaps"}, 32'(stall_lo), 32'd0);
        check({name, " result"}, result, exp_res);
        check({name, " rd_out"}, 32'(rd_out), 32'(rd));
        check({name, " stall@done"}, 32'(stall), 32'd0);
        last_rd  = rd;
        last_res = exp_res;
        @(negedge clk);
        check({name, " done-pulse"}, 32'(done), 32'd0);
        check({name, " idle-after"}, 32'(busy), 32'd0);
    endtask

    task automatic flush_at(input int fc, input string name);
        int dones;
        dones = 0;
        issue(3'd0, 32'h1234_5678, 32'h0000_0ABC, 5'd17);
        for (int c = 1; c <= fc; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check({name, " busy-before"}, 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        if (done) dones++;
        check({name, " no-done"}, 32'(dones), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " rd_out-kept"}, 32'(rd_out), 32'(last_rd));
        check({name, " result-kept"}, result, last_res);
    endtask

    initial begin
        int dones;
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [4:0]  rd;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 35};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 35};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 35};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 35};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 35};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 35};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        35};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         35};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         5'd14, 32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1};
        vecs[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 35};
        vecs[13] = '{3'd4, 32'h8000_0000,  32'd1,         5'd19, 32'h8000_0000, 35};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = '0; src_a = '0; src_b = '0; rd_in = '0;
        #3;
        check("reset busy",   32'(busy),   32'd0);
        check("reset stall",  32'(stall),  32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset result", result,      32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].lat,
                   $sformatf("vec%0d", i));

        flush_at(12, "flush-run");
        run_op(3'd5, 32'd9, 32'd3, 5'd20, 32'd3, 35, "divu-after-flush");
        flush_at(34, "flush-fix");

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd21);
        repeat (21) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun-reset busy",   32'(busy),   32'd0);
        check("midrun-reset stall",  32'(stall),  32'd0);
        check("midrun-reset done",   32'(done),   32'd0);
        check("midrun-reset result", result,      32'd0);
        check("midrun-reset rd_out", 32'(rd_out), 32'd0);
        last_rd = '0;
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("post-reset spurious done", 32'(dones), 32'd0);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4; rd_in = 5'd22;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("start+flush busy", 32'(busy), 32'd0);
        check("start+flush done", 32'(done), 32'd0);

        for (int i = 0; i < 60; i++) begin
            o  = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(1, 31));
            run_op(o, a, b, rd, ref_md(o, a, b), ref_lat(o, a, b), $sformatf("rand%0d op%0d", i, o));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the EX-stage RV32M multiply/divide resource.
- Accepts one operation from EX, runs an iterative shift-add multiply or restoring divide, and returns one result with its destination register.
- Raises the stall request that the hazard unit ORs into StallF/StallD; honours pipeline flushes from branch resolution.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  EX has a valid M-extension op this cycle
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
src_a  input  XLEN  rs1 operand (already forwarded)
src_b  input  XLEN  rs2 operand (already forwarded)
rd_in  input  5  destination register of the op
flush  input  1  kill the in-flight op (Eval_branch)
busy  output  1  state != IDLE
stall  output  1  stall request to the hazard unit
done  output  1  one-cycle result-valid pulse
result  output  XLEN  result, valid while done=1
rd_out  output  5  destination of the result, valid while done=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, stall and done=0; result=0; rd_out=0; counter and internal registers cleared. A reset mid-operation abandons the op and produces no done.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE, start=1, flush=0: latch op, rd_in, src_a, src_b.
  - Div by zero (op 4-7, src_b=0) or signed overflow (op 4/6, src_a=0x80000000, src_b=0xFFFFFFFF): load the fast result and go to DONE.
  - Otherwise go to PREP.
- IDLE, start=1 with flush=1: flush wins. Stay in IDLE, latch nothing.
- PREP (1 cycle): take absolute values of the signed operands per op (MULHSU: only src_a signed). Record result negate flag and remainder negate flag. Clear the accumulator. Counter=XLEN-1. Go to RUN.
- RUN (XLEN cycles): one partial-product add/shift or one restoring-subtract step per cycle. Decrement the counter. When counter=0 at the edge, go to FIX.
- FIX (1 cycle): apply two's-complement sign correction. Select low word (MUL), high word (MULH*), quotient (DIV*) or remainder (REM*) into result. Go to DONE.
- DONE (1 cycle): done=1, result and rd_out held stable. Next state is IDLE.
- Latency: with start sampled at edge 0, done is high in cycle XLEN+3 (35 for XLEN=32). The fast path gives done in cycle 1.
- stall = start in IDLE (combinational, holds EX on the issue cycle) OR state in {PREP, RUN, FIX}. stall=0 in DONE so the pipeline advances with the result.
- flush=1 in PREP, RUN or FIX: go to IDLE at the next edge, no done, rd_out unchanged. flush in DONE has no effect (the result is already committed to the pipeline).
- start while busy: ignored. The hazard unit guarantees no new issue until done.
- Fast results:
  - div-by-zero: quotient = all ones, remainder = src_a.
  - overflow: quotient = 0x80000000, remainder = 0.
- Arithmetic:
  - Multiply accumulator is 2*XLEN bits, unsigned internally; the result is negated in FIX if the flag is set.
  - Divide: remainder register XLEN+1 bits. The quotient takes the sign of a^b. The remainder takes the sign of the dividend.
- result keeps its last value outside DONE; only the DONE pulse qualifies it.

Decomposition:
- Shared package: op encodings (MD_MUL … MD_REMU), state encoding (S_IDLE … S_DONE), constants DIV0_Q and OVF_Q.
- One sub-module, muldiv_datapath: operand registers, accumulator, shift/add/subtract step and sign fix-up, driven by load/step/fix strobes.
- muldiv_sequencer keeps the FSM, counter, flush/stall logic and the fast-path decode.

Test Plan:
- MUL 7 × -3 (src_a=7, src_b=0xFFFFFFFD, rd_in=5) -> stall high cycles 0..34; done in cycle 35 with result=0xFFFFFFEB, rd_out=5.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result=0xFFFFFFFE after 35 cycles; MULH same operands -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> done in cycle 1, result=0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> done in cycle 1, result=0x80000000; REM same operands -> 0.
- Start MUL, assert flush in RUN cycle 10 -> IDLE next edge, no done; a new DIVU 9/3 started immediately -> done in cycle 35, result=3.
- Drive rst_n low in RUN cycle 20 -> busy, stall and done=0 immediately; after release, no spurious done for 40 cycles; start+flush in the same IDLE cycle -> stays IDLE.
